// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU sequencer slice: unit-select
//               encodings, sequencer FSM state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default operand width and default unit-response timeout.
  localparam int c_DATA_WD_DEF = 16;
  localparam int c_TIMEOUT_DEF = 4;

  // Number of execution units behind the sequencer.
  localparam int c_UNIT_CNT = 4;

  // Unit select, taken from CMD_FUN[3:2].
  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_sel_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_result_mux.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_mux
// Description : Combinational 4:1 selection of a unit result and its
//               result-valid flag by the latched unit select.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int OUT_WD = c_DATA_WD_DEF
) (
  input  logic [1:0]        i_sel,
  input  logic [OUT_WD-1:0] i_arith_out,
  input  logic [OUT_WD-1:0] i_logic_out,
  input  logic [OUT_WD-1:0] i_cmp_out,
  input  logic [OUT_WD-1:0] i_shift_out,
  input  logic              i_arith_flag,
  input  logic              i_logic_flag,
  input  logic              i_cmp_flag,
  input  logic              i_shift_flag,
  output logic [OUT_WD-1:0] o_out,
  output logic              o_flag
);

  // Route only the selected unit; all other flags are invisible downstream.
  always_comb begin
    o_out  = '0;
    o_flag = 1'b0;
    case (i_sel)
      UNIT_ARITH: begin o_out = i_arith_out; o_flag = i_arith_flag; end
      UNIT_LOGIC: begin o_out = i_logic_out; o_flag = i_logic_flag; end
      UNIT_CMP:   begin o_out = i_cmp_out;   o_flag = i_cmp_flag;   end
      UNIT_SHIFT: begin o_out = i_shift_out; o_flag = i_shift_flag; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Accepts one command at a time, drives operands and a single
//               unit enable, waits (bounded) for the unit's result flag and
//               presents the captured result or a timeout error through a
//               valid/ready handshake. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int IN_DATA_WD = c_DATA_WD_DEF,
  parameter int OUT_WD     = IN_DATA_WD,
  parameter int TIMEOUT    = c_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [IN_DATA_WD-1:0] CMD_A,
  input  logic [IN_DATA_WD-1:0] CMD_B,
  input  logic [3:0]            CMD_FUN,
  output logic [IN_DATA_WD-1:0] A,
  output logic [IN_DATA_WD-1:0] B,
  output logic [1:0]            ALU_FUN,
  output logic                  ARITH_EN,
  output logic                  LOGIC_EN,
  output logic                  CMP_EN,
  output logic                  SHIFT_EN,
  input  logic [OUT_WD-1:0]     ARITH_OUT,
  input  logic [OUT_WD-1:0]     LOGIC_OUT,
  input  logic [OUT_WD-1:0]     CMP_OUT,
  input  logic [OUT_WD-1:0]     SHIFT_OUT,
  input  logic                  ARITH_FLAG,
  input  logic                  LOGIC_FLAG,
  input  logic                  CMP_FLAG,
  input  logic                  SHIFT_FLAG,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [OUT_WD-1:0]     RES_DATA,
  output logic                  RES_ERR
);

  // Counter is wide enough to hold TIMEOUT itself, so it never wraps.
  localparam int                    CNT_WD        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WD-1:0]     c_TIMEOUT_CNT = CNT_WD'(TIMEOUT);
  localparam logic [c_UNIT_CNT-1:0] c_EN_ONE      = c_UNIT_CNT'(1);

  seq_state_e              r_state,     w_state;
  logic                    r_cmd_ready, w_cmd_ready;
  logic [IN_DATA_WD-1:0]   r_a,         w_a;
  logic [IN_DATA_WD-1:0]   r_b,         w_b;
  logic [1:0]              r_fun,       w_fun;
  logic [1:0]              r_sel,       w_sel;
  logic [c_UNIT_CNT-1:0]   r_en,        w_en;
  logic [CNT_WD-1:0]       r_cnt,       w_cnt;
  logic                    r_res_valid, w_res_valid;
  logic [OUT_WD-1:0]       r_res_data,  w_res_data;
  logic                    r_res_err,   w_res_err;

  logic [CNT_WD-1:0]       w_cnt_inc;
  logic [OUT_WD-1:0]       w_sel_out;
  logic                    w_sel_flag;

  assign w_cnt_inc = r_cnt + CNT_WD'(1);

  alu_result_mux #(
    .OUT_WD (OUT_WD)
  ) u_result_mux (
    .i_sel        (r_sel),
    .i_arith_out  (ARITH_OUT),
    .i_logic_out  (LOGIC_OUT),
    .i_cmp_out    (CMP_OUT),
    .i_shift_out  (SHIFT_OUT),
    .i_arith_flag (ARITH_FLAG),
    .i_logic_flag (LOGIC_FLAG),
    .i_cmp_flag   (CMP_FLAG),
    .i_shift_flag (SHIFT_FLAG),
    .o_out        (w_sel_out),
    .o_flag       (w_sel_flag)
  );

  // State and registered outputs; async reset drops any in-flight command.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_a         <= '0;
      r_b         <= '0;
      r_fun       <= '0;
      r_sel       <= '0;
      r_en        <= '0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_a         <= w_a;
      r_b         <= w_b;
      r_fun       <= w_fun;
      r_sel       <= w_sel;
      r_en        <= w_en;
      r_cnt       <= w_cnt;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
      r_res_err   <= w_res_err;
    end
  end

  // Next state and next output values; everything holds unless changed.
  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_a         = r_a;
    w_b         = r_b;
    w_fun       = r_fun;
    w_sel       = r_sel;
    w_en        = r_en;
    w_cnt       = r_cnt;
    w_res_valid = r_res_valid;
    w_res_data  = r_res_data;
    w_res_err   = r_res_err;
    case (r_state)
      IDLE: begin
        if (CMD_VALID && r_cmd_ready) begin
          w_a         = CMD_A;
          w_b         = CMD_B;
          w_fun       = CMD_FUN[1:0];
          w_sel       = CMD_FUN[3:2];
          w_en        = c_EN_ONE << CMD_FUN[3:2];
          w_cnt       = '0;
          w_cmd_ready = 1'b0;
          w_state     = BUSY;
        end
      end
      BUSY: begin
        w_cnt = w_cnt_inc;
        // The unit clears OUT once EN drops, so capture on the flag edge;
        // a flag arriving on the timeout edge still counts as success.
        if (w_sel_flag) begin
          w_en        = '0;
          w_res_data  = w_sel_out;
          w_res_err   = 1'b0;
          w_res_valid = 1'b1;
          w_state     = DONE;
        end else if (w_cnt_inc == c_TIMEOUT_CNT) begin
          w_en        = '0;
          w_res_data  = '0;
          w_res_err   = 1'b1;
          w_res_valid = 1'b1;
          w_state     = DONE;
        end
      end
      DONE: begin
        if (RES_READY) begin
          w_res_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = IDLE;
        end
      end
      default: begin
        w_state     = IDLE;
        w_cmd_ready = 1'b1;
        w_en        = '0;
        w_res_valid = 1'b0;
      end
    endcase
  end

  assign CMD_READY = r_cmd_ready;
  assign A         = r_a;
  assign B         = r_b;
  assign ALU_FUN   = r_fun;
  assign ARITH_EN  = r_en[0];
  assign LOGIC_EN  = r_en[1];
  assign CMP_EN    = r_en[2];
  assign SHIFT_EN  = r_en[3];
  assign RES_VALID = r_res_valid;
  assign RES_DATA  = r_res_data;
  assign RES_ERR   = r_res_err;

endmodule
`default_nettype wire
